// File: rtl/game_pkg.sv
// game_pkg: turn-state encoding and default board geometry shared by the
// turn sequencer and the renderers (QBOX_X / FINISH_X come from here).
package game_pkg;

  localparam int TILE_W          = 4;
  localparam int TILE_X0_DEF     = 20;
  localparam int TILE_PITCH_DEF  = 60;
  localparam int FINISH_TILE_DEF = 10;
  localparam int QBOX_TILE_DEF   = 3;

  localparam int QBOX_X   = TILE_X0_DEF + QBOX_TILE_DEF * TILE_PITCH_DEF;
  localparam int FINISH_X = TILE_X0_DEF + FINISH_TILE_DEF * TILE_PITCH_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROLL,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_GAME_OVER
  } turn_state_t;

endpackage

// File: rtl/turn_watchdog.sv
// turn_watchdog: down-counter loaded on entry to the wait state; expire_o
// pulses in the LIMIT-th consecutive enabled cycle after the load.
module turn_watchdog #(
  parameter int LIMIT = 1 << 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] START = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // reload on load, otherwise count down to the terminal count and hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = START;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: two-player turn flow driving the ui_render move interface.
// Optional question-box bonus move: define TURN_SEQ_QBOX_BONUS_EN.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | waiting for the active player's roll request
// ST_ROLL      | advance active player's tile, register its target x
// ST_ISSUE     | one-cycle pos_valid strobe, load watchdog
// ST_WAIT_DONE | waiting for turn_done or watchdog expiry
// ST_CHECK     | finish / bonus / hand over the turn
// ST_GAME_OVER | terminal until reset
module turn_sequencer
  import game_pkg::*;
#(
  parameter int TILE_X0        = TILE_X0_DEF,
  parameter int TILE_PITCH     = TILE_PITCH_DEF,
  parameter int FINISH_TILE    = FINISH_TILE_DEF,
  parameter int QBOX_TILE      = QBOX_TILE_DEF,
  parameter int QBOX_BONUS     = 2,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] roll_req,
  input  logic [2:0] dice_value,
  input  logic       turn_done,
  output logic [9:0] player1_pos_x,
  output logic [9:0] player2_pos_x,
  output logic       pos_valid,
  output logic       active_player,
  output logic [2:0] dice_shown,
  output logic       busy,
  output logic       game_over,
  output logic       winner,
  output logic       timeout_err
);

  localparam logic [TILE_W:0]   FIN_W  = (TILE_W + 1)'(FINISH_TILE);
  localparam logic [TILE_W-1:0] FIN_T  = TILE_W'(FINISH_TILE);
  localparam logic [9:0]        X0_RST = 10'(TILE_X0);

  turn_state_t       state_q, state_d;
  logic [TILE_W-1:0] tile1_q, tile1_d, tile2_q, tile2_d;
  logic [9:0]        pos1_q, pos1_d, pos2_q, pos2_d;
  logic [2:0]        dice_q, dice_d;
  logic              active_q, active_d;
  logic              winner_q, winner_d;
  logic              tmo_q, tmo_d;
  logic [TILE_W-1:0] cur_tile, new_tile;
  logic              upd;
  logic              wd_load, wd_en, wd_expire;

`ifdef TURN_SEQ_QBOX_BONUS_EN
  localparam logic [TILE_W-1:0] QBOX_T = TILE_W'(QBOX_TILE);
  logic bonus_used_q, bonus_used_d;
`else
  // bonus parameters stay in the interface so both builds share one instance
  logic unused_bonus_cfg;
  assign unused_bonus_cfg = ^{QBOX_TILE, QBOX_BONUS};
`endif

  // tile + increment, saturated at the finish tile (sum can exceed 4 bits)
  function automatic logic [TILE_W-1:0] tile_add(input logic [TILE_W-1:0] t,
                                                 input logic [TILE_W:0]   inc);
    logic [TILE_W:0] s;
    s = {1'b0, t} + inc;
    if (s > FIN_W) s = FIN_W;
    return s[TILE_W-1:0];
  endfunction

  function automatic logic [9:0] tile_x(input logic [TILE_W-1:0] t);
    return 10'(TILE_X0) + 10'(t) * 10'(TILE_PITCH);
  endfunction

  function automatic logic [2:0] clamp_dice(input logic [2:0] d);
    logic [2:0] r;
    case (d)
      3'd0:    r = 3'd1;
      3'd7:    r = 3'd6;
      default: r = d;
    endcase
    return r;
  endfunction

  assign cur_tile = active_q ? tile2_q : tile1_q;

  turn_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (wd_load),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // next-state and per-player tile/position updates
  always_comb begin
    state_d  = state_q;
    tile1_d  = tile1_q;
    tile2_d  = tile2_q;
    pos1_d   = pos1_q;
    pos2_d   = pos2_q;
    dice_d   = dice_q;
    active_d = active_q;
    winner_d = winner_q;
    tmo_d    = tmo_q;
    wd_load  = 1'b0;
    wd_en    = 1'b0;
    upd      = 1'b0;
    new_tile = cur_tile;
`ifdef TURN_SEQ_QBOX_BONUS_EN
    bonus_used_d = bonus_used_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (roll_req[active_q]) begin
          dice_d  = dice_value;
          state_d = ST_ROLL;
`ifdef TURN_SEQ_QBOX_BONUS_EN
          bonus_used_d = 1'b0;
`endif
        end
      end
      ST_ROLL: begin
        new_tile = tile_add(cur_tile, (TILE_W + 1)'(clamp_dice(dice_q)));
        upd      = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        wd_load = 1'b1;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_en = 1'b1;
        if (turn_done) begin
          state_d = ST_CHECK;
        end else if (wd_expire) begin
          tmo_d   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cur_tile == FIN_T) begin
          winner_d = active_q;
          state_d  = ST_GAME_OVER;
`ifdef TURN_SEQ_QBOX_BONUS_EN
        end else if ((cur_tile == QBOX_T) && !bonus_used_q) begin
          new_tile     = tile_add(cur_tile, (TILE_W + 1)'(QBOX_BONUS));
          upd          = 1'b1;
          bonus_used_d = 1'b1;
          state_d      = ST_ISSUE;
`endif
        end else begin
          active_d = ~active_q;
          state_d  = ST_IDLE;
        end
      end
      ST_GAME_OVER: state_d = ST_GAME_OVER;
      default:      state_d = ST_IDLE;
    endcase

    if (upd) begin
      if (active_q) begin
        tile2_d = new_tile;
        pos2_d  = tile_x(new_tile);
      end else begin
        tile1_d = new_tile;
        pos1_d  = tile_x(new_tile);
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tile1_q  <= '0;
      tile2_q  <= '0;
      pos1_q   <= X0_RST;
      pos2_q   <= X0_RST;
      dice_q   <= '0;
      active_q <= 1'b0;
      winner_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tile1_q  <= tile1_d;
      tile2_q  <= tile2_d;
      pos1_q   <= pos1_d;
      pos2_q   <= pos2_d;
      dice_q   <= dice_d;
      active_q <= active_d;
      winner_q <= winner_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef TURN_SEQ_QBOX_BONUS_EN
  // bonus granted at most once per turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bonus_used_q <= 1'b0;
    else        bonus_used_q <= bonus_used_d;
  end
`endif

  assign player1_pos_x = pos1_q;
  assign player2_pos_x = pos2_q;
  assign pos_valid     = (state_q == ST_ISSUE);
  assign active_player = active_q;
  assign dice_shown    = dice_q;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_GAME_OVER);
  assign game_over     = (state_q == ST_GAME_OVER);
  assign winner        = winner_q;
  assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: transaction-level model of the turn rules, compared
// against the DUT outputs every cycle, plus directed literal checks.
module tb_turn_sequencer;

  localparam int T   = 16;
  localparam int FIN = 10;
  localparam int QB  = 3;
  localparam int BON = 2;
`ifdef TURN_SEQ_QBOX_BONUS_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] roll_req = 2'b00;
  logic [2:0] dice_value = 3'd0;
  logic       turn_done = 1'b0;
  logic [9:0] player1_pos_x, player2_pos_x;
  logic       pos_valid, active_player, busy, game_over, winner, timeout_err;
  logic [2:0] dice_shown;

  turn_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .roll_req      (roll_req),
    .dice_value    (dice_value),
    .turn_done     (turn_done),
    .player1_pos_x (player1_pos_x),
    .player2_pos_x (player2_pos_x),
    .pos_valid     (pos_valid),
    .active_player (active_player),
    .dice_shown    (dice_shown),
    .busy          (busy),
    .game_over     (game_over),
    .winner        (winner),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  bit cmp_en = 1'b0;

  int m_tile [2];
  int e_pos  [2];
  int e_valid, e_active, e_busy, e_go, e_win, e_tmo, e_dice;

  function automatic int x_of(input int t);
    return 20 + 60 * t;
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tile[0] = 0; m_tile[1] = 0;
    e_pos[0] = 20; e_pos[1] = 20;
    e_valid = 0; e_active = 0; e_busy = 0; e_go = 0;
    e_win = 0; e_tmo = 0; e_dice = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_p1_x"}, player1_pos_x, 20);
    chk({tag, "_p2_x"}, player2_pos_x, 20);
    chk({tag, "_valid"}, pos_valid, 0);
    chk({tag, "_active"}, active_player, 0);
    chk({tag, "_dice"}, dice_shown, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pos_valid", pos_valid, e_valid);
      chk("player1_pos_x", player1_pos_x, e_pos[0]);
      chk("player2_pos_x", player2_pos_x, e_pos[1]);
      chk("active_player", active_player, e_active);
      chk("dice_shown", dice_shown, e_dice);
      chk("busy", busy, e_busy);
      chk("game_over", game_over, e_go);
      chk("winner", winner, e_win);
      chk("timeout_err", timeout_err, e_tmo);
    end
  end

  always @(negedge clk) if (pos_valid) n_valid++;

  task automatic cyc();
    @(posedge clk);
    #1;
    roll_req  = 2'b00;
    turn_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        if (e_go != 0) roll_req = 2'($urandom);
        else if ($urandom_range(1, 0) == 1) roll_req = (e_active != 0) ? 2'b01 : 2'b10;
        turn_done = 1'($urandom);
      end
      cyc();
    end
  endtask

  // one full turn, starting in an IDLE cycle; done_k = WAIT cycle carrying
  // turn_done (> T withholds it), rst_k = WAIT cycle in which reset hits
  task automatic do_turn(input logic [2:0] dice, input int done_k,
                         input bit noise, input int rst_k);
    int p, cl;
    bit used;
    p = e_active;
    roll_req = (p != 0) ? 2'b10 : 2'b01;
    if (noise && ($urandom_range(1, 0) == 1)) roll_req = 2'b11;
    dice_value = dice;
    cyc();
    dice_value = 3'($urandom);
    e_busy = 1;
    e_dice = dice;
    cl = (dice == 0) ? 1 : (dice == 7) ? 6 : int'(dice);
    m_tile[p] = mn(m_tile[p] + cl, FIN);
    if (noise) begin roll_req = 2'($urandom); turn_done = 1'($urandom); end
    cyc();
    used = 0;
    forever begin
      e_pos[p] = x_of(m_tile[p]);
      e_valid = 1;
      if (noise) begin roll_req = 2'($urandom); turn_done = 1'($urandom); end
      cyc();
      e_valid = 0;
      for (int k = 1; k <= T; k++) begin
        if (k == rst_k) begin
          #2;
          rst_n = 1'b0;
          model_reset();
          #1;
          check_reset_outputs("midwait_rst");
          return;
        end
        if (noise) roll_req = 2'($urandom);
        if (k == done_k) turn_done = 1'b1;
        cyc();
        if (k == done_k) break;
        if (k == T) e_tmo = 1;
      end
      if (noise) begin roll_req = 2'($urandom); turn_done = 1'($urandom); end
      cyc();
      if (m_tile[p] == FIN) begin
        e_go = 1; e_win = p; e_busy = 0;
        return;
      end
      if (BONUS_EN && (m_tile[p] == QB) && !used) begin
        used = 1;
        m_tile[p] = mn(m_tile[p] + BON, FIN);
        continue;
      end
      e_active = 1 - p;
      e_busy = 0;
      return;
    end
  endtask

  initial begin
    int dk;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    cmp_en = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;

    // first roll by player 1
    n_valid = 0;
    do_turn(3'd4, 10, 1'b0, 0);
    chk("t1_p1_x", player1_pos_x, 260);
    chk("t1_p2_x", player2_pos_x, 20);
    chk("t1_active", active_player, 1);
    chk("t1_valid_count", n_valid, 1);

    // wrong player's button is ignored, then clamped dice 0
    for (int i = 0; i < 3; i++) begin
      roll_req = 2'b01;
      cyc();
    end
    chk("wrong_btn_busy", busy, 0);
    chk("wrong_btn_valid_count", n_valid, 1);
    do_turn(3'd0, 5, 1'b0, 0);
    chk("t2_p2_x", player2_pos_x, 80);
    chk("t2_active", active_player, 0);

    // question box
    do_reset();
    n_valid = 0;
    do_turn(3'd3, 4, 1'b0, 0);
    chk("qbox_p1_x", player1_pos_x, BONUS_EN ? 320 : 200);
    chk("qbox_valid_count", n_valid, BONUS_EN ? 2 : 1);
    chk("qbox_active", active_player, 1);

    // finish clamp and game over
    do_reset();
    do_turn(3'd1, 3, 1'b0, 0);
    do_turn(3'd6, 3, 1'b0, 0);
    do_turn(3'd5, 3, 1'b0, 0);
    do_turn(3'd2, 3, 1'b0, 0);
    chk("pre_fin_p2_x", player2_pos_x, 500);
    do_turn(3'd1, 3, 1'b0, 0);
    n_valid = 0;
    do_turn(3'd5, 7, 1'b0, 0);
    chk("fin_p2_x", player2_pos_x, 620);
    chk("fin_over", game_over, 1);
    chk("fin_winner", winner, 1);
    idle(10, 1'b1);
    chk("after_over_valid_count", n_valid, 1);
    chk("after_over_busy", busy, 0);

    // watchdog expiry, then turn_done exactly in the expiry cycle
    do_reset();
    do_turn(3'd2, T + 3, 1'b0, 0);
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_active", active_player, 1);
    do_reset();
    do_turn(3'd2, T, 1'b0, 0);
    chk("edge_done_tmo", timeout_err, 0);
    chk("edge_done_active", active_player, 1);

    // reset in the middle of WAIT_DONE, then a fresh roll
    do_reset();
    do_turn(3'd5, 0, 1'b0, 6);
    cyc();
    rst_n = 1'b1;
    do_turn(3'd2, 3, 1'b0, 0);
    chk("post_rst_p1_x", player1_pos_x, 140);
    chk("post_rst_active", active_player, 1);

    // randomized games with input noise
    for (int g = 0; g < 12; g++) begin
      do_reset();
      for (int t = 0; (t < 40) && (e_go == 0); t++) begin
        idle($urandom_range(2, 0), 1'b1);
        dk = ($urandom_range(9, 0) == 0) ? T + 5 : $urandom_range(T, 1);
        do_turn(3'($urandom), dk, 1'b1, 0);
      end
      idle(5, 1'b1);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
